redundant_normalizer: RTL and testbench



---
 rtl/redundant_normalizer.sv | 173 +++++++++++++++++
 tb/tb_redundant_normalizer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/redundant_normalizer.sv
// Converts one redundant-form {carry, val} limb polynomial into a canonical
// field element in [0, MOD): serial carry resolution, then bounded MOD correction.
module redundant_normalizer #(
  parameter int                     N_LIMB   = 4,
  parameter int                     LW       = 64,
  parameter int                     CW       = 8,
  parameter logic [N_LIMB*LW-1:0]   MOD      = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
  parameter int                     MAX_ITER = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N_LIMB*(CW+LW)-1:0]  in_poly,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [N_LIMB*LW-1:0]       out_data,
  output logic                       out_err
);

  localparam int VW  = N_LIMB * LW;
  localparam int AW  = VW + CW + 2;
  localparam int LMW = CW + LW;
  localparam int TW  = LW + CW + 2;
  localparam int KW  = (N_LIMB > 1) ? $clog2(N_LIMB) : 1;
  localparam int IW  = $clog2(MAX_ITER + 1);

  localparam logic signed [AW-1:0] MOD_EXT = $signed({{(CW + 2){1'b0}}, MOD});
  localparam logic [KW-1:0]        K_LAST  = KW'(N_LIMB - 1);
  localparam logic [IW-1:0]        IT_MAX  = IW'(MAX_ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROP = 2'd1,
    RED  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t                    state_r, state_nxt_s;
  logic [N_LIMB*LMW-1:0]     poly_r, poly_nxt_s;
  logic signed [AW-1:0]      acc_r, acc_nxt_s;
  logic signed [CW+1:0]      rc_r, rc_nxt_s;
  logic [KW-1:0]             k_r, k_nxt_s;
  logic [IW-1:0]             it_r, it_nxt_s;
  logic                      valid_r, valid_nxt_s;
  logic                      err_r, err_nxt_s;
  logic                      ready_r, ready_nxt_s;

  logic [LMW-1:0]            limb_s [N_LIMB];
  logic [LW-1:0]             val_k_s;
  logic [CW-1:0]             carry_k_s;
  logic [TW-1:0]             t_s;
  logic [CW+1:0]             rc_prop_s;
  logic                      acc_neg_s;
  logic                      acc_ge_s;

  // Unpack the captured polynomial into limbs and resolve the current limb's carry.
  always_comb begin
    for (int i = 0; i < N_LIMB; i++) begin
      limb_s[i] = poly_r[i*LMW +: LMW];
    end
    val_k_s   = limb_s[k_r][LW-1:0];
    carry_k_s = limb_s[k_r][LMW-1:LW];
    // Upper CW+2 bits of t are exactly t >>> LW truncated to the running-carry width.
    t_s       = {{(CW + 2){1'b0}}, val_k_s} + {{LW{rc_r[CW+1]}}, rc_r};
    rc_prop_s = t_s[TW-1:LW] + {{2{carry_k_s[CW-1]}}, carry_k_s};
    acc_neg_s = acc_r[AW-1];
    acc_ge_s  = (acc_r >= MOD_EXT);
  end

  // Next-state and datapath control for the IDLE/PROP/RED/DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    poly_nxt_s  = poly_r;
    acc_nxt_s   = acc_r;
    rc_nxt_s    = rc_r;
    k_nxt_s     = k_r;
    it_nxt_s    = it_r;
    valid_nxt_s = valid_r;
    err_nxt_s   = err_r;
    case (state_r)
      IDLE: begin
        if (in_valid && ready_r) begin
          poly_nxt_s  = in_poly;
          rc_nxt_s    = '0;
          k_nxt_s     = '0;
          it_nxt_s    = '0;
          err_nxt_s   = 1'b0;
          state_nxt_s = PROP;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      PROP: begin
        for (int i = 0; i < N_LIMB; i++) begin
          if (k_r == KW'(i)) begin
            acc_nxt_s[i*LW +: LW] = t_s[LW-1:0];
          end else begin
            acc_nxt_s[i*LW +: LW] = acc_r[i*LW +: LW];
          end
        end
        rc_nxt_s = rc_prop_s;
        if (k_r == K_LAST) begin
          acc_nxt_s[AW-1:VW] = rc_prop_s;
          state_nxt_s        = RED;
        end else begin
          k_nxt_s = k_r + 1'b1;
        end
      end
      RED: begin
        if (!acc_neg_s && !acc_ge_s) begin
          state_nxt_s = DONE;
          valid_nxt_s = 1'b1;
          err_nxt_s   = 1'b0;
        end else if (it_r == IT_MAX) begin
          state_nxt_s = DONE;
          valid_nxt_s = 1'b1;
          err_nxt_s   = 1'b1;
        end else if (acc_neg_s) begin
          acc_nxt_s = acc_r + MOD_EXT;
          it_nxt_s  = it_r + 1'b1;
        end else begin
          acc_nxt_s = acc_r - MOD_EXT;
          it_nxt_s  = it_r + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          valid_nxt_s = 1'b0;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        valid_nxt_s = 1'b0;
        state_nxt_s = IDLE;
      end
    endcase
    ready_nxt_s = (state_nxt_s == IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r <= IDLE;
      poly_r  <= '0;
      acc_r   <= '0;
      rc_r    <= '0;
      k_r     <= '0;
      it_r    <= '0;
      valid_r <= 1'b0;
      err_r   <= 1'b0;
      ready_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      poly_r  <= poly_nxt_s;
      acc_r   <= acc_nxt_s;
      rc_r    <= rc_nxt_s;
      k_r     <= k_nxt_s;
      it_r    <= it_nxt_s;
      valid_r <= valid_nxt_s;
      err_r   <= err_nxt_s;
      ready_r <= ready_nxt_s;
    end
  end

  assign in_ready  = ready_r;
  assign out_valid = valid_r;
  assign out_err   = err_r;
  assign out_data  = acc_r[VW-1:0];

endmodule

// File: tb/tb_redundant_normalizer.sv
// Directed bench for redundant_normalizer: an arithmetic model of the encoded
// value checked every cycle, plus literal expectations per transaction.
`timescale 1ns/1ps
module tb_redundant_normalizer;

  localparam int N_LIMB = 4;
  localparam int LW     = 64;
  localparam int CW     = 8;
  localparam int LMW    = CW + LW;
  localparam int PW     = N_LIMB * LMW;
  localparam int VW     = N_LIMB * LW;
  localparam logic [VW-1:0] MOD = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  logic          clk       = 1'b0;
  logic          rstn      = 1'b0;
  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [PW-1:0] in_poly   = '0;
  logic          in_ready;
  logic          out_valid;
  logic          out_err;
  logic [VW-1:0] out_data;

  int            total = 0;
  int            bad   = 0;

  int            edge_cnt   = 0;
  logic          m_pending  = 1'b0;
  int            m_acc_edge = 0;
  logic [264:0]  m_res      = '0;
  int            m_rise;
  logic          m_exp_valid;

  always #5 clk = ~clk;

  redundant_normalizer dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_poly   (in_poly),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  task automatic chk_v(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk(input logic [VW-1:0] vals, input logic [N_LIMB*CW-1:0] cars);
    logic [PW-1:0] p;
    p = '0;
    for (int i = 0; i < N_LIMB; i++) begin
      p[i*LMW +: LMW] = {cars[i*CW +: CW], vals[i*LW +: LW]};
    end
    return p;
  endfunction

  // Result = {latency, err, data}: value V from the limb formula, then at most 16 MOD steps.
  function automatic logic [264:0] model(input logic [PW-1:0] p);
    logic signed [299:0] v, t, m;
    logic signed [7:0]   c;
    int                  n;
    m = $signed({44'd0, MOD});
    v = '0;
    for (int i = 0; i < N_LIMB; i++) begin
      c = p[i*LMW+LW +: CW];
      t = c;
      t = t <<< LW;
      t = t + $signed({236'd0, p[i*LMW +: LW]});
      v = v + (t <<< (LW * i));
    end
    n = 0;
    while (n < 16 && (v < 0 || v >= m)) begin
      v = (v < 0) ? v + m : v - m;
      n++;
    end
    return {8'(5 + n), (v < 0 || v >= m), v[255:0]};
  endfunction

  assign m_rise = m_acc_edge + int'(m_res[264:257]);

  // Transaction model: tracks acceptance edge, expected result and handshake release.
  always @(posedge clk) begin
    edge_cnt <= edge_cnt + 1;
    if (!rstn) begin
      m_pending <= 1'b0;
    end else if (!m_pending) begin
      if (in_valid) begin
        m_pending  <= 1'b1;
        m_acc_edge <= edge_cnt;
        m_res      <= model(in_poly);
      end
    end else if (out_ready && edge_cnt > m_rise) begin
      m_pending <= 1'b0;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (edge_cnt > 0) begin
        m_exp_valid = m_pending && (edge_cnt - 1 >= m_rise);
        chk_i("out_valid", int'(out_valid), int'(m_exp_valid));
        chk_i("in_ready", int'(in_ready), int'(!m_pending));
        if (m_exp_valid) begin
          chk_v("out_data", out_data, m_res[255:0]);
          chk_i("out_err", int'(out_err), int'(m_res[256]));
        end
      end
    end
  end

  task automatic send(input logic [PW-1:0] p);
    in_poly  = p;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cnt);
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    if (cnt >= 200) begin
      total++;
      bad++;
      $display("FAIL wait_valid: got no out_valid within %0d cycles", cnt);
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run(input string name, input logic [PW-1:0] p, input logic [VW-1:0] xd,
                     input int xe, input int xlat);
    int lat;
    send(p);
    wait_valid(lat);
    chk_i({name, "_lat"}, lat, xlat);
    chk_v({name, "_data"}, out_data, xd);
    chk_i({name, "_err"}, int'(out_err), xe);
    release_out();
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    chk_i("rst_valid", int'(out_valid), 0);
    chk_i("rst_ready", int'(in_ready), 1);
    chk_i("rst_err", int'(out_err), 0);
    chk_v("rst_data", out_data, 256'd0);

    run("small", mk(256'd5, 32'd0), 256'd5, 0, 5);
    run("carry0", mk({192'd0, 64'hFFFF_FFFF_FFFF_FFFF}, 32'h0000_0001),
        256'h1_FFFF_FFFF_FFFF_FFFF, 0, 5);
    run("eq_mod", mk(MOD, 32'd0), 256'd0, 0, 6);
    run("neg", mk(256'd0, 32'h0000_00FF),
        256'h30644e72e131a029b85045b68181585d97816a916871ca8c3c208c16d87cfd47, 0, 6);
    run("err", mk(256'd0, 32'h7F00_0000),
        256'hF9BB18D1ECE5FD647AFBA497E7EA7A2687E956E978E3572C3DF73E9278302B90, 1, 21);

    // Backpressure with a second request waiting on the input side.
    send(mk(256'd9, 32'd0));
    wait_valid(lat);
    chk_i("bp_lat", lat, 5);
    in_poly  = mk(MOD + 256'd3, 32'd0);
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_i("bp_ready", int'(in_ready), 0);
      chk_i("bp_valid", int'(out_valid), 1);
      chk_v("bp_data", out_data, 256'd9);
      chk_i("bp_err", int'(out_err), 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk_i("bp_rel_valid", int'(out_valid), 0);
    chk_i("bp_rel_ready", int'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(lat);
    chk_i("bp2_lat", lat, 6);
    chk_v("bp2_data", out_data, 256'd3);
    chk_i("bp2_err", int'(out_err), 0);
    release_out();

    // Reset two cycles into carry propagation.
    send(mk(256'd5, 32'd0));
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk_i("mid_rst_valid", int'(out_valid), 0);
    chk_i("mid_rst_ready", int'(in_ready), 1);
    rstn = 1'b1;
    run("after_rst", mk(256'd7, 32'd0), 256'd7, 0, 5);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
